// File: rtl/gate_delay_pkg.sv
// Shared types and helpers for the inertial-delay gate array.
// gate_eval is the single definition of the per-channel gate function.
package gate_delay_pkg;

  typedef enum logic [1:0] {
    OP_NOT = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } gate_op_e;

  function automatic logic gate_eval(input gate_op_e op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Counter width: max(1, clog2(delay)); DELAY=1 still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned delay);
    int unsigned w;
    w = $clog2(delay);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gate_delay_cell.sv
// One inertial-delay channel: z follows t only after t has differed from z
// on DELAY consecutive edges; chg pulses in the cycle the new z is visible.
module gate_delay_cell
  import gate_delay_pkg::*;
#(
  parameter int unsigned DELAY = 10,
  parameter logic        INIT  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic z,
  output logic chg
);

  localparam int unsigned    CW = cnt_width(DELAY);
  localparam logic [CW-1:0]  TC = CW'(DELAY - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      z   <= INIT;
      cnt <= '0;
      chg <= 1'b0;
    end else begin
      chg <= 1'b0;
      if (t == z) begin
        // Any edge where the target agrees with the output restarts the count.
        cnt <= '0;
      end else if (cnt == TC) begin
        z   <= t;
        cnt <= '0;
        chg <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gate_delay_array.sv
// WIDTH independent inertial-delay gates sharing one runtime-selected function.
// The top only decodes op, forms the per-channel targets and reduces settled.
module gate_delay_array
  import gate_delay_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DELAY = 10,
  parameter logic        INIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] chg,
  output logic             settled
);

  if (DELAY < 1) begin : g_bad_delay
    $error("gate_delay_array: DELAY must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("gate_delay_array: WIDTH must be >= 1");
  end

  gate_op_e         op_sel;
  logic [WIDTH-1:0] t;

  assign op_sel = gate_op_e'(op);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    assign t[i] = gate_eval(op_sel, a[i], b[i]);

    gate_delay_cell #(
      .DELAY (DELAY),
      .INIT  (INIT)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t[i]),
      .z   (z[i]),
      .chg (chg[i])
    );
  end

  // Combinational on purpose: drops in the same cycle an input moves a target.
  assign settled = &(t ~^ z);

endmodule

// File: tb/tb_gate_delay_array.sv
// Directed bench for gate_delay_array: four configurations exercise delay,
// glitch filtering, op switching, reset-discard and the DELAY=1 registered case.
module tb_gate_delay_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // dut1: WIDTH=1 DELAY=10 INIT=0
  logic       rst1;
  logic [1:0] op1;
  logic [0:0] a1, b1, z1, chg1;
  logic       settled1;
  // dut2: WIDTH=4 DELAY=3 INIT=0
  logic       rst2;
  logic [1:0] op2;
  logic [3:0] a2, b2, z2, chg2;
  logic       settled2;
  // dut3: WIDTH=2 DELAY=5 INIT=1
  logic       rst3;
  logic [1:0] op3;
  logic [1:0] a3, b3, z3, chg3;
  logic       settled3;
  // dut4: WIDTH=8 DELAY=1 INIT=0
  logic       rst4;
  logic [1:0] op4;
  logic [7:0] a4, b4, z4, chg4;
  logic       settled4;

  gate_delay_array #(.WIDTH(1), .DELAY(10), .INIT(1'b0)) dut1 (
    .clk(clk), .rst(rst1), .op(op1), .a(a1), .b(b1), .z(z1), .chg(chg1), .settled(settled1));
  gate_delay_array #(.WIDTH(4), .DELAY(3), .INIT(1'b0)) dut2 (
    .clk(clk), .rst(rst2), .op(op2), .a(a2), .b(b2), .z(z2), .chg(chg2), .settled(settled2));
  gate_delay_array #(.WIDTH(2), .DELAY(5), .INIT(1'b1)) dut3 (
    .clk(clk), .rst(rst3), .op(op3), .a(a3), .b(b3), .z(z3), .chg(chg3), .settled(settled3));
  gate_delay_array #(.WIDTH(8), .DELAY(1), .INIT(1'b0)) dut4 (
    .clk(clk), .rst(rst4), .op(op4), .a(a4), .b(b4), .z(z4), .chg(chg4), .settled(settled4));

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] z;
    logic [7:0] chg;
  } vec_t;

  vec_t vecs [8];

  // One rising edge, then return at the falling edge where outputs are stable.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    // DELAY=1 table: z is the gate of the previous cycle's inputs, chg = z ^ old z.
    vecs[0] = '{op: 2'b00, a: 8'hF0, b: 8'h00, z: 8'h0F, chg: 8'h0F};
    vecs[1] = '{op: 2'b01, a: 8'hCC, b: 8'hAA, z: 8'h88, chg: 8'h87};
    vecs[2] = '{op: 2'b10, a: 8'hCC, b: 8'hAA, z: 8'hEE, chg: 8'h66};
    vecs[3] = '{op: 2'b11, a: 8'hCC, b: 8'hAA, z: 8'h66, chg: 8'h88};
    vecs[4] = '{op: 2'b11, a: 8'h66, b: 8'h66, z: 8'h00, chg: 8'h66};
    vecs[5] = '{op: 2'b00, a: 8'h00, b: 8'h5A, z: 8'hFF, chg: 8'hFF};
    vecs[6] = '{op: 2'b01, a: 8'hFF, b: 8'h0F, z: 8'h0F, chg: 8'hF0};
    vecs[7] = '{op: 2'b10, a: 8'h30, b: 8'h03, z: 8'h33, chg: 8'h3C};

    rst1 = 1'b1; op1 = 2'b00; a1 = 1'b0; b1 = 1'b0;
    rst2 = 1'b1; op2 = 2'b11; a2 = 4'b1100; b2 = 4'b1010;
    rst3 = 1'b1; op3 = 2'b01; a3 = 2'b00; b3 = 2'b00;
    rst4 = 1'b1; op4 = 2'b00; a4 = 8'h00; b4 = 8'h00;
    @(negedge clk);
    tick();
    tick();

    // ---- 1: NOT(0) from reset, z rises after exactly 10 edges ----
    chk("t1_rst_z", z1, 8'h00);
    chk("t1_rst_chg", chg1, 8'h00);
    chk("t1_rst_settled", settled1, 8'h00);
    rst1 = 1'b0;
    for (int e = 0; e < 9; e++) begin
      tick();
      chk($sformatf("t1_hold_z_e%0d", e), z1, 8'h00);
      chk($sformatf("t1_hold_chg_e%0d", e), chg1, 8'h00);
      chk($sformatf("t1_hold_settled_e%0d", e), settled1, 8'h00);
    end
    tick();
    chk("t1_upd_z", z1, 8'h01);
    chk("t1_upd_chg", chg1, 8'h01);
    chk("t1_upd_settled", settled1, 8'h01);
    tick();
    chk("t1_after_chg", chg1, 8'h00);
    chk("t1_after_z", z1, 8'h01);

    // ---- 2: 4-cycle glitch filtered, then a held change lands after 10 ----
    a1 = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      chk($sformatf("t2_glitch_z_e%0d", e), z1, 8'h01);
      chk($sformatf("t2_glitch_chg_e%0d", e), chg1, 8'h00);
    end
    a1 = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      chk($sformatf("t2_post_z_e%0d", e), z1, 8'h01);
      chk($sformatf("t2_post_chg_e%0d", e), chg1, 8'h00);
      chk($sformatf("t2_post_settled_e%0d", e), settled1, 8'h01);
    end
    a1 = 1'b1;
    for (int e = 0; e < 9; e++) begin
      tick();
      chk($sformatf("t2_held_z_e%0d", e), z1, 8'h01);
    end
    tick();
    chk("t2_held_upd_z", z1, 8'h00);
    chk("t2_held_upd_chg", chg1, 8'h01);

    // ---- 3: XOR from reset, DELAY=3 ----
    chk("t3_rst_z", z2, 8'h00);
    chk("t3_rst_settled", settled2, 8'h00);
    rst2 = 1'b0;
    tick();
    tick();
    chk("t3_e2_z", z2, 8'h00);
    chk("t3_e2_chg", chg2, 8'h00);
    tick();
    chk("t3_e3_z", z2, 8'h06);
    chk("t3_e3_chg", chg2, 8'h06);
    chk("t3_e3_settled", settled2, 8'h01);
    tick();
    chk("t3_e4_chg", chg2, 8'h00);
    chk("t3_e4_settled", settled2, 8'h01);

    // ---- 4: op glitch of 2 cycles filtered, held op change applies ----
    op2 = 2'b01; a2 = 4'hF; b2 = 4'hF;
    for (int e = 0; e < 4; e++) tick();
    chk("t4_and_z", z2, 8'h0F);
    chk("t4_and_chg", chg2, 8'h00);
    chk("t4_and_settled", settled2, 8'h01);
    op2 = 2'b00;
    tick();
    tick();
    chk("t4_not2_z", z2, 8'h0F);
    chk("t4_not2_settled", settled2, 8'h00);
    op2 = 2'b01;
    for (int e = 0; e < 3; e++) begin
      tick();
      chk($sformatf("t4_back_z_e%0d", e), z2, 8'h0F);
      chk($sformatf("t4_back_chg_e%0d", e), chg2, 8'h00);
    end
    op2 = 2'b00;
    tick();
    tick();
    chk("t4_hold_z", z2, 8'h0F);
    tick();
    chk("t4_upd_z", z2, 8'h00);
    chk("t4_upd_chg", chg2, 8'h0F);

    // ---- 5: reset mid-count discards it; full 5-edge count restarts ----
    chk("t5_rst_z", z3, 8'h03);
    rst3 = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      chk($sformatf("t5_pre_z_e%0d", e), z3, 8'h03);
    end
    rst3 = 1'b1;
    tick();
    chk("t5_mid_rst_z", z3, 8'h03);
    chk("t5_mid_rst_chg", chg3, 8'h00);
    chk("t5_mid_rst_settled", settled3, 8'h00);
    rst3 = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      chk($sformatf("t5_restart_z_e%0d", e), z3, 8'h03);
      chk($sformatf("t5_restart_chg_e%0d", e), chg3, 8'h00);
    end
    tick();
    chk("t5_upd_z", z3, 8'h00);
    chk("t5_upd_chg", chg3, 8'h03);
    chk("t5_upd_settled", settled3, 8'h01);

    // ---- 6: DELAY=1 behaves as a registered gate ----
    chk("t6_rst_z", z4, 8'h00);
    chk("t6_rst_chg", chg4, 8'h00);
    rst4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      op4 = vecs[i].op;
      a4  = vecs[i].a;
      b4  = vecs[i].b;
      tick();
      chk($sformatf("t6_v%0d_z", i), z4, vecs[i].z);
      chk($sformatf("t6_v%0d_chg", i), chg4, vecs[i].chg);
      chk($sformatf("t6_v%0d_settled", i), settled4, 8'h01);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_delay_array.md
# gate_delay_array

Parametrised, clocked multi-channel logic gate with a programmable inertial propagation delay, expressed in clock cycles. It is the synthesisable successor to the single delayed NOT gate used in the gate-modelling experiments. It provides WIDTH independent channels and a runtime-selectable function (NOT/AND/OR/XOR). Pulses shorter than DELAY cycles are filtered, as a real inertial gate would filter them. It sits between lab stimulus logic (switches, pattern generators) and observed outputs (LEDs, waveform capture).

## Interface
- WIDTH, 8, number of independent channels (≥1)
- DELAY, 10, inertial delay in clock cycles (≥1; elaboration error otherwise)
- INIT, 1'b0, value loaded into every output bit on reset
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- op  input  2  gate function: 00 NOT(a), 01 a AND b, 10 a OR b, 11 a XOR b; shared by all channels
- a  input  WIDTH  operand A per channel
- b  input  WIDTH  operand B per channel (ignored for NOT)
- z  output  WIDTH  delayed gate output per channel
- chg  output  WIDTH  one-cycle pulse on channel i in the cycle after z[i] changes
- settled  output  1  high when every channel's target equals its z (no pending change)

## Operation
- Per channel i, the target is t[i] = f(op, a[i], b[i]), computed combinationally from the current inputs.
- Each channel has a counter cnt[i] of width CW = max(1, $clog2(DELAY)).
- At each rising edge, when not in reset:
  - If t[i] == z[i]: cnt[i] ← 0.
  - Else if cnt[i] == DELAY-1: z[i] ← t[i], cnt[i] ← 0, chg[i] ← 1.
  - Else: cnt[i] ← cnt[i]+1.
- chg[i] ← 0 in every cycle not covered by the update case above.
- Inertial rule: z[i] follows t[i] only after t[i] has differed from z[i] on DELAY consecutive sampling edges. Any edge where t[i] == z[i] restarts the count.
- A change of op or a mid-count is equivalent to a change of t[i]. Because channels are single-bit, the count continues while t[i] ≠ z[i] and is cleared only when t[i] returns to z[i].
- Channels are fully independent; any number may update on the same edge.
- settled = &(t ~^ z), combinational.
- Reset, synchronous at any edge with rst=1 and overriding everything: z ← {WIDTH{INIT}}, cnt ← 0, chg ← 0.
  - Reset during a pending count discards that count.
  - After reset release, channels whose target differs from INIT begin counting on the first edge with rst=0.

## Timing
- Inputs are sampled at the rising edge. A target difference first sampled at edge k, and held, updates z at edge k+DELAY-1. z is visible in the following cycle, so latency is DELAY cycles.
- DELAY=1 gives a plain registered gate with 1-cycle latency.
- A target pulse lasting fewer than DELAY sampling edges never reaches z, and chg stays 0.
- chg[i] is high for exactly the cycle in which the new z[i] value is first visible.
- settled is combinational and may drop in the same cycle an input changes.
- Reset values:
  - z = {WIDTH{INIT}}
  - chg = 0
  - settled = 1 only if every t[i] == INIT for the current inputs

## Structure
- Package gate_delay_pkg:
  - enum gate_op_e {OP_NOT=2'b00, OP_AND=2'b01, OP_OR=2'b10, OP_XOR=2'b11}
  - pure function gate_eval(op, a, b) returning 1 bit
- Sub-module gate_delay_cell implements one channel (counter, z/chg registers, parameter DELAY/INIT). It is instantiated WIDTH times in a generate loop. The top level holds only the op decode and the settled reduction.

## Test plan
1. WIDTH=1, DELAY=10, INIT=0, op=NOT, a=0, rst released at edge r -> z stays 0 through edge r+8, z=1 visible after edge r+9, chg high for that single cycle, settled=0 until then.
2. Same configuration, hold a=0 until settled, then a=1 for 4 cycles and back to 0 -> z stays 1 and chg stays 0 throughout (glitch filtered); then a=1 held -> z=0 exactly 10 cycles after the first sampled edge.
3. WIDTH=4, DELAY=3, op=XOR, a=4'b1100, b=4'b1010 from reset (INIT=0) -> z=4'b0110 on the third post-reset edge, chg=4'b0110 in that cycle, settled=1 afterwards.
4. WIDTH=4, DELAY=3, settled with op=AND, a=b=4'b1111 (z=4'b1111); switch op=NOT for 2 cycles, then back to AND -> z unchanged, no chg; keep op=NOT -> z=4'b0000 after 3 edges.
5. DELAY=5, pending count at cnt=3 on a channel, assert rst for one edge -> z=INIT and cnt=0 immediately; after release, the full 5-edge count restarts.
6. DELAY=1, WIDTH=8, random a/b/op each cycle -> z equals the previous cycle's gate_eval for every bit, and chg equals z XOR previous z.
